// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller for the multicycle MIPS datapath: it reads one word
// from instruction memory at the latched PC and strobes it into the instruction register.
module instr_fetch_ctrl #(
    parameter int unsigned TIMEOUT     = 16,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [31:0] pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic        IRWrite,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] count_reg;

    // Every output is a flop; strobes are set on the transition into the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            pc_next    <= '0;
            instr_out  <= RESET_INSTR;
            IRWrite    <= 1'b0;
            pc_write   <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            IRWrite  <= 1'b0;
            pc_write <= 1'b0;
            fault    <= 1'b0;
            if (flush && state_reg != IDLE) begin
                state_reg <= IDLE;
                mem_req   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (fetch_start) begin
                            busy <= 1'b1;
                            if (pc[1:0] != 2'b00) begin
                                state_reg  <= ERR;
                                fault      <= 1'b1;
                                fault_code <= 2'b01;
                            end else begin
                                state_reg  <= REQ;
                                mem_req    <= 1'b1;
                                mem_addr   <= pc;
                                pc_next    <= pc + 32'd4;
                                fault_code <= 2'b00;
                            end
                        end
                    end
                    REQ: begin
                        if (mem_ready) begin
                            mem_req <= 1'b0;
                            if (mem_rvalid) begin
                                state_reg <= DONE;
                                instr_out <= mem_rdata;
                                IRWrite   <= 1'b1;
                                pc_write  <= 1'b1;
                            end else begin
                                state_reg <= WAIT;
                                count_reg <= '0;
                            end
                        end
                    end
                    WAIT: begin
                        // A response on the final counted cycle still completes the fetch.
                        if (mem_rvalid) begin
                            state_reg <= DONE;
                            instr_out <= mem_rdata;
                            IRWrite   <= 1'b1;
                            pc_write  <= 1'b1;
                        end else if (count_reg == COUNT_LAST) begin
                            state_reg  <= ERR;
                            fault      <= 1'b1;
                            fault_code <= 2'b10;
                        end else begin
                            count_reg <= count_reg + 8'd1;
                        end
                    end
                    DONE, ERR: begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed plan steps plus random fetches, each checked
// against a per-transaction timing model derived from the fetch rules.
module tb_instr_fetch_ctrl;

    localparam int          TIMEOUT     = 16;
    localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic        flush;
    logic [31:0] pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] instr_out;
    logic        ir_write;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int tests = 0;
    int fails = 0;

    // Architectural state the bench expects the block to hold between fetches.
    logic [31:0] m_instr;
    logic [31:0] m_pc_next;
    logic [31:0] m_addr;
    logic [1:0]  m_code;

    instr_fetch_ctrl #(
        .TIMEOUT    (TIMEOUT),
        .RESET_INSTR(RESET_INSTR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fetch_start(fetch_start),
        .flush      (flush),
        .pc         (pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .instr_out  (instr_out),
        .IRWrite    (ir_write),
        .pc_next    (pc_next),
        .pc_write   (pc_write),
        .busy       (busy),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {27'd0, mem_req, ir_write, pc_write, fault, busy};
    endfunction

    // One fetch: memory accepts d_r cycles after the first REQ cycle and returns data
    // dv cycles after acceptance (dv = 0 same cycle, dv < 0 never).
    task automatic run_fetch(input string name, input logic [31:0] p, input int d_r,
                             input int dv, input logic [31:0] data);
        logic        aligned;
        logic        done;
        int          e;
        int          rv_cycle;
        logic [31:0] exp_vec;
        aligned  = (p[1:0] == 2'b00);
        rv_cycle = (dv > 0) ? 1 + d_r + dv : -1;
        if (!aligned) begin
            e = 1; done = 1'b0;
        end else if (dv == 0) begin
            e = 2 + d_r; done = 1'b1;
        end else if (dv > 0 && dv <= TIMEOUT) begin
            e = 2 + d_r + dv; done = 1'b1;
        end else begin
            e = 2 + d_r + TIMEOUT; done = 1'b0;
        end

        fetch_start = 1'b1;
        pc          = p;
        flush       = 1'b0;
        mem_ready   = 1'($urandom);
        mem_rvalid  = 1'($urandom);
        mem_rdata   = $urandom;
        tick();
        for (int c = 1; c <= e + 1; c++) begin
            exp_vec = {27'd0, (aligned && c <= 1 + d_r), (done && c == e), (done && c == e),
                       (!done && c == e), (c <= e)};
            chk($sformatf("%s strobes c=%0d", name, c), strobes(), exp_vec);
            if (aligned && c <= 1 + d_r)
                chk($sformatf("%s mem_addr c=%0d", name, c), mem_addr, p);
            fetch_start = (c <= e) ? 1'($urandom) : 1'b0;
            pc          = $urandom;
            mem_rdata   = $urandom;
            if (aligned && c <= d_r) begin
                mem_ready  = 1'b0;
                mem_rvalid = 1'($urandom);
            end else if (aligned && c == 1 + d_r) begin
                mem_ready  = 1'b1;
                mem_rvalid = (dv == 0);
                if (dv == 0) mem_rdata = data;
            end else if (aligned && c < e) begin
                mem_ready  = 1'($urandom);
                mem_rvalid = (c == rv_cycle);
                if (c == rv_cycle) mem_rdata = data;
            end else begin
                mem_ready  = 1'($urandom);
                mem_rvalid = 1'($urandom);
            end
            tick();
        end
        fetch_start = 1'b0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;

        if (aligned) begin
            m_addr    = p;
            m_pc_next = p + 32'd4;
        end
        if (done) m_instr = data;
        m_code = !aligned ? 2'b01 : (done ? 2'b00 : 2'b10);
        chk({name, " instr_out"}, instr_out, m_instr);
        chk({name, " pc_next"}, pc_next, m_pc_next);
        chk({name, " mem_addr"}, mem_addr, m_addr);
        chk({name, " fault_code"}, {30'd0, fault_code}, {30'd0, m_code});
        $display("[TB] %s pc=%h d_r=%0d dv=%0d end=%0d done=%0b instr=%h", name, p, d_r, dv, e, done, instr_out);
    endtask

    initial begin
        logic [31:0] rp;
        int          rdr;
        int          rdv;
        int          sel;
        reset       = 1'b1;
        fetch_start = 1'b0;
        flush       = 1'b0;
        pc          = '0;
        mem_ready   = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        repeat (3) tick();
        chk("reset strobes", strobes(), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset pc_next", pc_next, 32'd0);
        chk("reset instr_out", instr_out, RESET_INSTR);
        chk("reset fault_code", {30'd0, fault_code}, 32'd0);
        #3 reset = 1'b0;
        tick();
        m_instr   = RESET_INSTR;
        m_pc_next = '0;
        m_addr    = '0;
        m_code    = 2'b00;

        run_fetch("zero_wait", 32'h0040_0000, 0, 0, 32'h2008_0005);
        run_fetch("wait_states", 32'h0040_0004, 2, 3, 32'h8C09_0000);
        run_fetch("misaligned", 32'h0040_0002, 0, 0, 32'h1111_1111);
        run_fetch("timeout", 32'h0040_0008, 0, -1, 32'h2222_2222);
        run_fetch("rvalid_last", 32'h0040_000C, 0, TIMEOUT, 32'h3C01_1234);
        run_fetch("rvalid_late", 32'h0040_0010, 1, TIMEOUT + 1, 32'h3333_3333);
        run_fetch("pc_wrap", 32'hFFFF_FFFC, 1, 1, 32'h0800_0040);

        // Flush in WAIT coinciding with a response: nothing is captured.
        fetch_start = 1'b1; pc = 32'h0040_0100;
        tick();
        fetch_start = 1'b0;
        chk("flush req", strobes(), 32'b10001);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("flush wait0", strobes(), 32'b00001);
        tick();
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; mem_rvalid = 1'b0;
        chk("flush idle", strobes(), 32'd0);
        chk("flush instr_out", instr_out, m_instr);
        tick();
        chk("flush after", strobes(), 32'd0);
        chk("flush pc_next", pc_next, 32'h0040_0104);
        chk("flush fault_code", {30'd0, fault_code}, 32'd0);
        m_addr = 32'h0040_0100; m_pc_next = 32'h0040_0104; m_code = 2'b00;
        $display("[TB] flush_in_wait instr=%h", instr_out);

        // Asynchronous reset while in REQ, then a stray response.
        fetch_start = 1'b1; pc = 32'h0040_0200;
        tick();
        fetch_start = 1'b0;
        chk("rst req", strobes(), 32'b10001);
        #2 reset = 1'b1;
        #1;
        chk("rst async strobes", strobes(), 32'd0);
        chk("rst async mem_addr", mem_addr, 32'd0);
        chk("rst async pc_next", pc_next, 32'd0);
        chk("rst async instr_out", instr_out, RESET_INSTR);
        #2 reset = 1'b0;
        tick();
        mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("rst stray strobes", strobes(), 32'd0);
        chk("rst stray instr_out", instr_out, RESET_INSTR);
        tick();
        chk("rst stray after", strobes(), 32'd0);
        m_instr = RESET_INSTR; m_pc_next = '0; m_addr = '0; m_code = 2'b00;
        $display("[TB] reset_in_req instr=%h", instr_out);

        for (int i = 0; i < 40; i++) begin
            rp = $urandom;
            if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
            rdr = $urandom_range(0, 4);
            sel = $urandom_range(0, 9);
            if (sel == 0)      rdv = -1;
            else if (sel == 1) rdv = TIMEOUT + 1;
            else if (sel == 2) rdv = TIMEOUT;
            else               rdv = $urandom_range(0, 6);
            run_fetch($sformatf("rand%0d", i), rp, rdr, rdv, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
